// File: rtl/dm_lsu_pkg.sv
// dm_lsu_pkg: shared types and constants for the data-memory load/store unit.
//   state_e   - LSU FSM state encoding
//   size_e    - access size encoding carried on req_size
//   misaligned() - alignment check for a given size and byte offset
package dm_lsu_pkg;

    localparam int unsigned ADDR_W_DEF = 12;
    localparam int unsigned DATA_W_DEF = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_e;

    function automatic logic misaligned(input size_e sz, input logic [2:0] off);
        logic bad;
        case (sz)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = off[0];
            SZ_W:    bad = |off[1:0];
            default: bad = |off;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dm_lsu_if.sv
// dm_lsu_if: request/response handshake from the core plus the data-memory bus.
//   master - core side: drives req_*, receives req_ready and rsp_*
//   slave  - LSU side: the reverse, plus drives dm_* and receives dm_dataRead
//   mem    - data-memory side: receives dm_*, drives dm_dataRead
interface dm_lsu_if
    import dm_lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
);

    logic                valid_unused_placeholder;
    logic                req_valid;
    logic                req_ready;
    logic                req_we;
    logic [ADDR_W+2:0]   req_addr;
    logic [1:0]          req_size;
    logic                req_signed;
    logic [DATA_W-1:0]   req_wdata;

    logic                rsp_valid;
    logic [DATA_W-1:0]   rsp_rdata;
    logic                rsp_err;

    logic [ADDR_W-1:0]   dm_direccion;
    logic [DATA_W-1:0]   dm_dataWrite;
    logic                dm_enableWr;
    logic                dm_bitAddress;
    logic [DATA_W-1:0]   dm_dataRead;

    assign valid_unused_placeholder = 1'b0;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_signed, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_signed, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output dm_direccion, dm_dataWrite, dm_enableWr, dm_bitAddress,
        input  dm_dataRead
    );

    modport mem (
        input  dm_direccion, dm_dataWrite, dm_enableWr, dm_bitAddress,
        output dm_dataRead
    );

endinterface

// File: rtl/dm_lsu_lane.sv
// dm_lsu_lane: combinational byte-lane logic (little-endian).
//   rd_word  - 64-bit word read from data memory
//   offset   - byte offset within the word
//   size     - access size
//   sign_ext - sign-extend (1) or zero-extend (0) load data
//   wdata    - right-aligned store data
//   ld_data  - addressed lanes of rd_word, extended to 64 bits
//   st_word  - rd_word with wdata merged into the addressed lanes
module dm_lsu_lane
    import dm_lsu_pkg::*;
(
    input  logic [63:0] rd_word,
    input  logic [2:0]  offset,
    input  size_e       size,
    input  logic        sign_ext,
    input  logic [63:0] wdata,
    output logic [63:0] ld_data,
    output logic [63:0] st_word
);

    logic [5:0]  shift;
    logic [63:0] lane;
    logic [63:0] mask;
    logic [63:0] mask_sh;

    always_comb begin
        shift = {offset, 3'b000};
        lane  = rd_word >> shift;
        case (size)
            SZ_B: begin
                ld_data = sign_ext ? {{56{lane[7]}}, lane[7:0]} : {56'd0, lane[7:0]};
                mask    = 64'h0000_0000_0000_00FF;
            end
            SZ_H: begin
                ld_data = sign_ext ? {{48{lane[15]}}, lane[15:0]} : {48'd0, lane[15:0]};
                mask    = 64'h0000_0000_0000_FFFF;
            end
            SZ_W: begin
                ld_data = sign_ext ? {{32{lane[31]}}, lane[31:0]} : {32'd0, lane[31:0]};
                mask    = 64'h0000_0000_FFFF_FFFF;
            end
            default: begin
                ld_data = lane;
                mask    = '1;
            end
        endcase
        mask_sh = mask << shift;
        st_word = (rd_word & ~mask_sh) | ((wdata << shift) & mask_sh);
    end

endmodule

// File: rtl/dm_lsu.sv
// dm_lsu: load/store unit between the core and a 64-bit word data memory.
//   clk, rst_n - clock and asynchronous active-low reset
//   bus        - dm_lsu_if.slave: core request/response and DM bus
// Loads read one word and extract the addressed lanes; partial stores do a
// read-modify-write; double stores write directly; misaligned requests
// respond with rsp_err and touch nothing.
module dm_lsu
    import dm_lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
)(
    input logic     clk,
    input logic     rst_n,
    dm_lsu_if.slave bus
);

    state_e              state_q, state_d;
    logic [ADDR_W+2:0]   addr_q, addr_d;
    size_e               size_q, size_d;
    logic                sign_q, sign_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    logic [63:0]         ld_data;
    logic [63:0]         st_word;
    size_e               req_size_e;

    assign req_size_e = size_e'(bus.req_size);

    dm_lsu_lane u_lane (
        .rd_word  (bus.dm_dataRead),
        .offset   (addr_q[2:0]),
        .size     (size_q),
        .sign_ext (sign_q),
        .wdata    (wdata_q),
        .ld_data  (ld_data),
        .st_word  (st_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            size_q  <= SZ_B;
            sign_q  <= 1'b0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            sign_q  <= sign_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // wdata_q doubles as the write buffer: READ replaces it with the merged
    // word so WRITE always drives dm_dataWrite from the same register.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        sign_d  = sign_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    size_d  = req_size_e;
                    sign_d  = bus.req_signed;
                    we_d    = bus.req_we;
                    wdata_d = bus.req_wdata;
                    if (misaligned(req_size_e, bus.req_addr[2:0])) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = (bus.req_we && req_size_e == SZ_D) ? WRITE : READ;
                    end
                end
            end
            READ: begin
                if (we_q) begin
                    wdata_d = st_word;
                    state_d = WRITE;
                end else begin
                    rdata_d = ld_data;
                    state_d = RESP;
                end
            end
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready     = (state_q == IDLE);
        bus.rsp_valid     = (state_q == RESP);
        bus.rsp_err       = (state_q == RESP) && err_q;
        bus.rsp_rdata     = rdata_q;
        bus.dm_enableWr   = (state_q == WRITE);
        bus.dm_bitAddress = (state_q == WRITE);
        bus.dm_direccion  = addr_q[ADDR_W+2:3];
        bus.dm_dataWrite  = wdata_q;
    end

endmodule

// File: tb/tb_dm_lsu.sv
// tb_dm_lsu: directed self-checking bench for dm_lsu with a 4096-word DM model.
module tb_dm_lsu;
    import dm_lsu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic preload = 1'b1;

    always #5 clk = ~clk;

    dm_lsu_if #(.ADDR_W(12), .DATA_W(64)) bus ();

    dm_lsu #(.ADDR_W(12), .DATA_W(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [63:0] mem [4096];
    int wr_cnt  = 0;
    int acc_cnt = 0;
    int rsp_cnt = 0;
    int total   = 0;
    int passed  = 0;

    assign bus.dm_dataRead = mem[bus.dm_direccion];

    always @(posedge clk) begin
        if (preload) begin
            mem[12'h000] <= 64'h0000_8000_0000_0000;
            mem[12'h002] <= 64'h1111_1111_1111_1111;
            mem[12'h003] <= 64'h89AB_CDEF_0123_4567;
            mem[12'hFFF] <= 64'h0;
        end else if (bus.dm_enableWr && bus.dm_bitAddress) begin
            mem[bus.dm_direccion] <= bus.dm_dataWrite;
            wr_cnt <= wr_cnt + 1;
        end
        if (bus.req_valid && bus.req_ready) acc_cnt <= acc_cnt + 1;
        if (bus.rsp_valid) rsp_cnt <= rsp_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic run_req(input logic we, input logic [14:0] addr, input logic [1:0] sz,
                           input logic sg, input logic [63:0] wd,
                           output int lat, output int writes, output int en_seen,
                           output logic [11:0] wr_addr);
        int w0;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_addr   = addr;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_wdata  = wd;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        w0 = wr_cnt;
        lat = 0;
        en_seen = 0;
        wr_addr = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            lat++;
            if (bus.dm_enableWr) begin
                en_seen++;
                wr_addr = bus.dm_direccion;
            end
            if (bus.rsp_valid) break;
        end
        if (!bus.rsp_valid) lat = 99;
        writes = wr_cnt - w0;
    endtask

    initial begin
        int lat, writes, en_seen, w0, wt;
        logic [11:0] wa;
        logic [63:0] exp_b2b [3];
        logic [14:0] addr_b2b [3];
        logic [1:0]  size_b2b [3];

        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = '0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_wdata  = '0;

        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(bus.req_ready), 64'd1);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
        chk("rst_rdata", bus.rsp_rdata, 64'd0);
        chk("rst_dir", 64'(bus.dm_direccion), 64'd0);
        chk("rst_dwr", bus.dm_dataWrite, 64'd0);
        chk("rst_en", 64'({bus.dm_enableWr, bus.dm_bitAddress}), 64'd0);
        preload = 1'b0;
        rst_n = 1'b1;

        // Loads
        run_req(1'b0, 15'h0005, SZ_B, 1'b1, 64'd0, lat, writes, en_seen, wa);
        chk("lb_s_data", bus.rsp_rdata, 64'hFFFF_FFFF_FFFF_FF80);
        chk("lb_s_lat", 64'(lat), 64'd2);
        chk("lb_s_err", 64'(bus.rsp_err), 64'd0);
        chk("lb_s_wr", 64'(writes), 64'd0);
        run_req(1'b0, 15'h0005, SZ_B, 1'b0, 64'd0, lat, writes, en_seen, wa);
        chk("lb_u_data", bus.rsp_rdata, 64'h0000_0000_0000_0080);
        run_req(1'b0, 15'h001E, SZ_H, 1'b1, 64'd0, lat, writes, en_seen, wa);
        chk("lh_s_data", bus.rsp_rdata, 64'hFFFF_FFFF_FFFF_89AB);
        run_req(1'b0, 15'h001C, SZ_W, 1'b1, 64'd0, lat, writes, en_seen, wa);
        chk("lw_s_data", bus.rsp_rdata, 64'hFFFF_FFFF_89AB_CDEF);
        run_req(1'b0, 15'h0018, SZ_W, 1'b0, 64'd0, lat, writes, en_seen, wa);
        chk("lw_u_data", bus.rsp_rdata, 64'h0000_0000_0123_4567);
        run_req(1'b0, 15'h0018, SZ_D, 1'b0, 64'd0, lat, writes, en_seen, wa);
        chk("ld_data", bus.rsp_rdata, 64'h89AB_CDEF_0123_4567);
        chk("ld_lat", 64'(lat), 64'd2);

        // Partial store (read-modify-write)
        run_req(1'b1, 15'h0012, SZ_H, 1'b0, 64'h0000_0000_0000_BEEF, lat, writes, en_seen, wa);
        chk("sh_lat", 64'(lat), 64'd3);
        chk("sh_writes", 64'(writes), 64'd1);
        chk("sh_en_cycles", 64'(en_seen), 64'd1);
        chk("sh_mem", mem[12'h002], 64'h1111_1111_BEEF_1111);
        chk("sh_rdata_held", bus.rsp_rdata, 64'h89AB_CDEF_0123_4567);

        // Double store at the top word
        run_req(1'b1, 15'h7FF8, SZ_D, 1'b0, 64'hDEAD_BEEF_0123_4567, lat, writes, en_seen, wa);
        chk("sd_lat", 64'(lat), 64'd2);
        chk("sd_dir", 64'(wa), 64'hFFF);
        chk("sd_en_cycles", 64'(en_seen), 64'd1);
        chk("sd_mem", mem[12'hFFF], 64'hDEAD_BEEF_0123_4567);

        // Misaligned load
        run_req(1'b0, 15'h0006, SZ_W, 1'b1, 64'd0, lat, writes, en_seen, wa);
        chk("mis_ld_lat", 64'(lat), 64'd1);
        chk("mis_ld_err", 64'(bus.rsp_err), 64'd1);
        chk("mis_ld_rdata", bus.rsp_rdata, 64'd0);
        chk("mis_ld_en", 64'(en_seen), 64'd0);

        // Byte store, then misaligned word store leaves memory alone
        run_req(1'b1, 15'h0019, SZ_B, 1'b0, 64'h0000_0000_0000_00AA, lat, writes, en_seen, wa);
        chk("sb_mem", mem[12'h003], 64'h89AB_CDEF_0123_AA67);
        chk("sb_err", 64'(bus.rsp_err), 64'd0);
        run_req(1'b1, 15'h001A, SZ_W, 1'b0, 64'h0000_0000_1234_5678, lat, writes, en_seen, wa);
        chk("mis_st_err", 64'(bus.rsp_err), 64'd1);
        chk("mis_st_writes", 64'(writes), 64'd0);
        chk("mis_st_mem", mem[12'h003], 64'h89AB_CDEF_0123_AA67);

        // Reset during READ of a partial store aborts it
        w0 = wr_cnt;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_addr   = 15'h0010;
        bus.req_size   = SZ_B;
        bus.req_signed = 1'b0;
        bus.req_wdata  = 64'h55;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_ready", 64'(bus.req_ready), 64'd1);
        chk("abort_en", 64'(bus.dm_enableWr), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_writes", 64'(wr_cnt - w0), 64'd0);
        chk("abort_mem", mem[12'h002], 64'h1111_1111_BEEF_1111);
        run_req(1'b0, 15'h0010, SZ_D, 1'b0, 64'd0, lat, writes, en_seen, wa);
        chk("post_abort_ld", bus.rsp_rdata, 64'h1111_1111_BEEF_1111);
        chk("post_abort_lat", 64'(lat), 64'd2);

        // Back-to-back loads with req_valid held high throughout
        addr_b2b[0] = 15'h0018; size_b2b[0] = SZ_D; exp_b2b[0] = 64'h89AB_CDEF_0123_AA67;
        addr_b2b[1] = 15'h0010; size_b2b[1] = SZ_D; exp_b2b[1] = 64'h1111_1111_BEEF_1111;
        addr_b2b[2] = 15'h0005; size_b2b[2] = SZ_B; exp_b2b[2] = 64'h0000_0000_0000_0080;
        @(negedge clk);
        w0 = acc_cnt;
        wt = rsp_cnt;
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_signed = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.req_addr = addr_b2b[i];
            bus.req_size = size_b2b[i];
            for (int k = 0; k < 10 && !bus.req_ready; k++) @(negedge clk);
            @(posedge clk);
            @(negedge clk);
            lat = 1;
            while (!bus.rsp_valid && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            chk($sformatf("b2b_data%0d", i), bus.rsp_rdata, exp_b2b[i]);
            chk($sformatf("b2b_lat%0d", i), 64'(lat), 64'd2);
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("b2b_accepts", 64'(acc_cnt - w0), 64'd3);
        chk("b2b_rsps", 64'(rsp_cnt - wt), 64'd3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
